// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - Operation codes and shift-width helper shared by the riscv_alu slice.
package riscv_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_op_t;

    function automatic int shamt_width(input int wordsize);
        return $clog2(wordsize);
    endfunction

endpackage

// File: rtl/riscv_alu_shifter.sv
// rtl/riscv_alu_shifter.sv - Combinational barrel shifter for SLL/SRL/SRA.
module riscv_alu_shifter
    import riscv_alu_pkg::*;
#(
    parameter int WORDSIZE = 64,
    parameter int SHW      = shamt_width(WORDSIZE)
) (
    input  logic [WORDSIZE-1:0] a,
    input  logic [SHW-1:0]      shamt,
    input  alu_op_t             op,
    output logic [WORDSIZE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_SLL: y = a << shamt;
            ALU_SRL: y = a >> shamt;
            ALU_SRA: y = $signed(a) >>> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - Registered execute-stage ALU; optional zero flag under RISCV_ALU_ZERO_FLAG_EN.
module riscv_alu
    import riscv_alu_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] input_a,
    input  logic [WORDSIZE-1:0] input_b,
    input  logic [2:0]          operation,
    output logic                out_valid,
    output logic [WORDSIZE-1:0] result,
    output logic                overflow
`ifdef RISCV_ALU_ZERO_FLAG_EN
    ,
    output logic                zero
`endif
);

    localparam int SHW = shamt_width(WORDSIZE);

    alu_op_t             op;
    logic                is_sub;
    logic [WORDSIZE-1:0] b_eff;
    logic [WORDSIZE-1:0] sum;
    logic                add_ovf;
    logic [WORDSIZE-1:0] shift_y;
    logic [WORDSIZE-1:0] next_result;
    logic                next_overflow;

    assign op     = alu_op_t'(operation);
    assign is_sub = (op == ALU_SUB);

    // Single adder: SUB is A + ~B + 1, so one overflow rule covers both.
    assign b_eff   = is_sub ? ~input_b : input_b;
    assign sum     = input_a + b_eff + {{(WORDSIZE-1){1'b0}}, is_sub};
    assign add_ovf = (input_a[WORDSIZE-1] == b_eff[WORDSIZE-1]) &&
                     (sum[WORDSIZE-1] != input_a[WORDSIZE-1]);

    riscv_alu_shifter #(
        .WORDSIZE (WORDSIZE),
        .SHW      (SHW)
    ) u_shifter (
        .a     (input_a),
        .shamt (input_b[SHW-1:0]),
        .op    (op),
        .y     (shift_y)
    );

    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                next_result   = sum;
                next_overflow = add_ovf;
            end
            ALU_AND: next_result = input_a & input_b;
            ALU_OR:  next_result = input_a | input_b;
            ALU_XOR: next_result = input_a ^ input_b;
            default: next_result = shift_y;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= next_result;
                overflow <= next_overflow;
            end
        end
    end

`ifdef RISCV_ALU_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b1;
        end else if (in_valid) begin
            zero <= (next_result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_riscv_alu.sv
// tb/tb_riscv_alu.sv - Directed self-checking bench for riscv_alu.
module tb_riscv_alu;
    import riscv_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] input_a;
    logic [63:0] input_b;
    logic [2:0]  operation;
    logic        out_valid;
    logic [63:0] result;
    logic        overflow;
`ifdef RISCV_ALU_ZERO_FLAG_EN
    logic        zero;
`endif

    int checks = 0;
    int failures = 0;

    riscv_alu #(.WORDSIZE(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .input_a   (input_a),
        .input_b   (input_b),
        .operation (operation),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow)
`ifdef RISCV_ALU_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; input_a = '0; input_b = '0; operation = 3'b000;
        #1;
        checks++;
        if (result !== 64'h0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset result=%h overflow=%b out_valid=%b expected 0 0 0", result, overflow, out_valid);
        end
`ifdef RISCV_ALU_ZERO_FLAG_EN
        checks++;
        if (zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_zero zero=%b expected 1", zero);
        end
`endif
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_arith;
        logic [2:0]  ops[6] = '{ALU_ADD, ALU_SUB, ALU_SUB, ALU_ADD, ALU_SUB, ALU_ADD};
        logic [63:0] va[6]  = '{64'h5, 64'h5, 64'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] vb[6]  = '{64'h2, 64'h2, 64'h5, 64'h1, 64'h1, 64'h1};
        logic [63:0] er[6]  = '{64'h7, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0};
        logic        eo[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; operation = ops[i]; input_a = va[i]; input_b = vb[i];
            @(posedge clk); #1;
            checks++;
            if (result !== er[i] || overflow !== eo[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL arith[%0d] result=%h overflow=%b out_valid=%b expected %h %b 1",
                         i, result, overflow, out_valid, er[i], eo[i]);
            end
        end
    endtask

    task automatic test_logic_shift;
        logic [2:0]  ops[9] = '{ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLL, ALU_SRA, ALU_SRL};
        logic [63:0] va[9]  = '{64'hF0F0_0000_0000_00F0, 64'hF0F0_0000_0000_00F0, 64'hF0F0_0000_0000_00F0,
                                64'hF0F0_0000_0000_00F0, 64'hF0F0_0000_0000_00F0, 64'hF0F0_0000_0000_00F0,
                                64'hF0F0_0000_0000_00F0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
        logic [63:0] vb[9]  = '{64'h44, 64'h44, 64'h44, 64'h44, 64'h44, 64'h44, 64'hFFFF_0000_0000_00C4, 64'h3F, 64'h3F};
        logic [63:0] er[9]  = '{64'h0000_0000_0000_0040, 64'hF0F0_0000_0000_00F4, 64'hF0F0_0000_0000_00B4,
                                64'h0F00_0000_0000_0F00, 64'h0F0F_0000_0000_000F, 64'hFF0F_0000_0000_000F,
                                64'h0F00_0000_0000_0F00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            in_valid = 1'b1; operation = ops[i]; input_a = va[i]; input_b = vb[i];
            @(posedge clk); #1;
            checks++;
            if (result !== er[i] || overflow !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL logic_shift[%0d] result=%h overflow=%b out_valid=%b expected %h 0 1",
                         i, result, overflow, out_valid, er[i]);
            end
        end
    endtask

    task automatic test_back_to_back_hold;
        logic [63:0] er[3] = '{64'h3, 64'h30, 64'h1};
        // in_valid stays high across three consecutive edges
        @(negedge clk);
        in_valid = 1'b1; operation = ALU_ADD; input_a = 64'h1; input_b = 64'h2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== er[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d] result=%h out_valid=%b expected %h 1", i, result, out_valid, er[i]);
            end
            if (i == 0) begin operation = ALU_OR;  input_a = 64'h10; input_b = 64'h20; end
            if (i == 1) begin operation = ALU_SRL; input_a = 64'h8;  input_b = 64'h3;  end
        end
        @(negedge clk);
        in_valid = 1'b0; operation = ALU_ADD; input_a = 64'h7FFF_FFFF_FFFF_FFFF; input_b = 64'h1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== 64'h1 || overflow !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d] result=%h overflow=%b out_valid=%b expected 1 0 0", i, result, overflow, out_valid);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        in_valid = 1'b1; operation = ALU_ADD; input_a = 64'h7FFF_FFFF_FFFF_FFFF; input_b = 64'h1;
        @(posedge clk); #1;
        checks++;
        if (result !== 64'h8000_0000_0000_0000 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset result=%h overflow=%b expected 8000000000000000 1", result, overflow);
        end
        @(negedge clk);
        operation = ALU_XOR; input_a = 64'hAAAA; input_b = 64'h5555;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 64'h0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset result=%h overflow=%b out_valid=%b expected 0 0 0", result, overflow, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (result !== 64'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL inflight_lost result=%h out_valid=%b expected 0 0", result, out_valid);
        end
    endtask

`ifdef RISCV_ALU_ZERO_FLAG_EN
    task automatic test_zero_flag;
        logic [2:0]  ops[3] = '{ALU_SUB, ALU_ADD, ALU_AND};
        logic [63:0] va[3]  = '{64'h1234, 64'h5, 64'hF0};
        logic [63:0] vb[3]  = '{64'h1234, 64'h2, 64'h0F};
        logic        ez[3]  = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; operation = ops[i]; input_a = va[i]; input_b = vb[i];
            @(posedge clk); #1;
            checks++;
            if (zero !== ez[i]) begin
                failures++;
                $display("FAIL zero[%0d] zero=%b expected %b", i, zero, ez[i]);
            end
        end
        @(negedge clk); in_valid = 1'b0; input_a = 64'h9;
        @(posedge clk); #1;
        checks++;
        if (zero !== 1'b1) begin
            failures++;
            $display("FAIL zero_hold zero=%b expected 1", zero);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_logic_shift();
        test_back_to_back_hold();
        test_async_reset();
`ifdef RISCV_ALU_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_alu.md
# riscv_alu

Integer arithmetic/logic unit for the RISC-V datapath's execute stage. It takes two WORDSIZE-bit operands and a 3-bit operation code and produces a registered result plus a signed-overflow flag. Its output feeds the EX/MEM boundary.

## Interface
- WORDSIZE, default 64: operand and result width in bits. Legal values are 32 and 64.
- clk  input  1: single clock; everything samples on the rising edge.
- rst_n  input  1: asynchronous, active-low reset.
- in_valid  input  1: qualifies input_a, input_b and operation in the current cycle.
- input_a  input  WORDSIZE: operand A.
- input_b  input  WORDSIZE: operand B.
- operation  input  3: operation select.
- out_valid  output  1: result and overflow hold a new value.
- result  output  WORDSIZE: operation result.
- overflow  output  1: signed two's-complement overflow.
- zero  output  1: result equals zero. Present only with RISCV_ALU_ZERO_FLAG_EN.

## Operation
- 000 ADD: result = A + B, modulo 2^WORDSIZE.
- 001 SUB: result = A − B, modulo 2^WORDSIZE.
- 010 AND: bitwise A & B.
- 011 OR: bitwise A | B.
- 100 XOR: bitwise A ^ B.
- 101 SLL: A shifted left by B[log2(WORDSIZE)−1:0]. Upper bits of B are ignored.
- 110 SRL: logical right shift, same shift-amount rule as SLL.
- 111 SRA: arithmetic right shift, same shift-amount rule as SLL.
- Overflow flag:
  - ADD: 1 when A and B have the same sign and the sum's sign differs from it.
  - SUB: 1 when A and B have different signs and the result's sign differs from A's.
  - All other operations: 0.
- Overflow never inhibits result; the wrapped value is always written.
- Operands are unsigned bit vectors. Only the overflow rule and SRA interpret them as signed.

## Timing
- Latency is exactly 1 cycle: inputs sampled at edge N with in_valid=1 appear on result/overflow after edge N and remain stable through edge N+1.
- out_valid is in_valid delayed by one cycle.
- When in_valid=0: result and overflow hold their previous values, and out_valid=0 in the following cycle.
- Throughput is one operation per cycle. There is no backpressure.
- Reset (rst_n=0, asynchronous assert):
  - result = 0, overflow = 0, out_valid = 0, zero = 1.
  - Takes effect immediately, including mid-operation; an in-flight operation is discarded.
  - Deassertion is synchronous to clk. The first capture happens at the first rising edge with rst_n=1.
- Operation codes are fully decoded, so there are no illegal codes.

## Configuration
- RISCV_ALU_ZERO_FLAG_EN defined:
  - The zero output exists.
  - It is registered alongside result and equals (next result == 0).
  - It updates only when in_valid=1.
- Not defined: the port and its register are absent. All other behaviour is identical.

## Structure
- Package riscv_alu_pkg holds:
  - the 3-bit operation type;
  - named constants ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA;
  - a shift-amount width function, $clog2(WORDSIZE).
- One sub-module, riscv_alu_shifter: combinational barrel shifter covering SLL/SRL/SRA, parameterised by WORDSIZE.
- Add/sub share one adder, with B inverted and carry-in=1 for SUB.
- Output registers live in the top module.

## Test plan
- ADD, A=0x0000_0000_0000_0005, B=0x…0002, in_valid=1 → next cycle result=0x…0007, overflow=0, out_valid=1.
- SUB, A=0x…0005, B=0x…0002 → result=0x…0003, overflow=0. Then SUB A=2, B=5 → result=0xFFFF_FFFF_FFFF_FFFD, overflow=0.
- Overflow cases:
  - ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 → result=0x8000_0000_0000_0000, overflow=1.
  - SUB A=0x8000_0000_0000_0000, B=1 → result=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Logic and shifts with A=0xF0F0_0000_0000_00F0, B=0x0000_0000_0000_0044:
  - AND=0x…0040, OR=0xF0F0_0000_0000_00F4, XOR=0xF0F0_0000_0000_00B4.
  - SLL, SRL and SRA use shift amount 4 from B[5:0]; SRA sign-fills with 1s, i.e. 0xFF0F_0000_0000_000F.
- Throughput and hold: back-to-back operations on consecutive cycles each produce their result one cycle later. With in_valid=0, result holds its last value and out_valid drops to 0.
- Reset: assert rst_n=0 between clock edges while an operation is in flight → result=0, overflow=0, out_valid=0 immediately, and the in-flight operation is lost. With RISCV_ALU_ZERO_FLAG_EN defined, zero=1 after reset and zero=1 after SUB A=B=0x1234.
